pipe_rx_deframer: RTL and testbench

Single-clock receive buffer for host-to-FPGA pipe-in traffic, the inbound counterpart of the pipe transmit FIFO. The host writes fixed-length blocks of 16-bit words. The block advertises readiness only when a whole block fits, stores the words in an internal FIFO, and presents them to downstream logic (command decoder, waveform loader) over a valid/ready stream. Tracks block boundaries and flags overflow.

---
 rtl/pipe_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_pipe_rx_deframer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_deframer.sv
// Receive buffer for host pipe-in blocks: a word FIFO with block-boundary tracking,
// a registered valid/ready output stage and a sticky overflow flag.
module pipe_rx_deframer #(
  parameter int BLOCK_LEN = 1024,
  parameter int DEPTH     = 2048,
  parameter int AW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_we,
  input  logic [15:0]   pipe_din,
  output logic          wr_ready,
  output logic          out_valid,
  output logic [15:0]   out_data,
  input  logic          out_ready,
  output logic          block_done,
  output logic          overflow,
  output logic [AW:0]   level
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [AW:0]   DEPTH_V    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BLK_LEN_V  = (AW+1)'(BLOCK_LEN);
  localparam logic [AW:0]   BLK_LAST_V = (AW+1)'(BLOCK_LEN - 1);
  localparam logic [AW:0]   LVL_ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic          SINGLE_V   = (BLOCK_LEN == 1);

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   blk_cnt_r;
  state_t        state_r;

  logic          full_s;
  logic          wr_en_s;
  logic          pop_s;
  logic          rd_en_s;
  logic [AW:0]   space_s;
  logic          room_s;

  // Write acceptance, output-stage refill and block-space decisions for this cycle
  always_comb begin
    full_s  = (level == DEPTH_V);
    wr_en_s = pipe_we && !full_s;
    pop_s   = out_valid && out_ready;
    rd_en_s = (level != LVL_ZERO) && (!out_valid || pop_s);
    space_s = DEPTH_V - level;
    room_s  = (space_s >= BLK_LEN_V);
  end

  // Word storage; no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= pipe_din;
    end
  end

  // FIFO pointers, fill level, output register and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      level     <= LVL_ZERO;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // A pop without a refill empties the output stage
      if (rd_en_s) begin
        out_data  <= mem_r[rd_ptr_r];
        out_valid <= 1'b1;
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
      end else if (pop_s) begin
        out_valid <= 1'b0;
      end
      if (pipe_we && full_s) begin
        overflow <= 1'b1;
      end
    end
  end

  // Block framing: counts host words (dropped ones included) and paces wr_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      blk_cnt_r  <= LVL_ZERO;
      wr_ready   <= 1'b0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pipe_we) begin
            wr_ready <= 1'b0;
            if (SINGLE_V) begin
              blk_cnt_r  <= LVL_ZERO;
              block_done <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              blk_cnt_r <= LVL_ONE;
              state_r   <= ST_RECV;
            end
          end else begin
            wr_ready <= room_s;
          end
        end
        ST_RECV: begin
          wr_ready <= 1'b0;
          if (pipe_we) begin
            if (blk_cnt_r == BLK_LAST_V) begin
              blk_cnt_r  <= LVL_ZERO;
              block_done <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              blk_cnt_r <= blk_cnt_r + LVL_ONE;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          blk_cnt_r <= LVL_ZERO;
          wr_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_rx_deframer.sv
// Randomized bench for pipe_rx_deframer: a queue-based model of memory plus output
// register is stepped every clock and compared with the default-sized DUT; a second
// BLOCK_LEN=1, DEPTH=4 instance is exercised directly.
module tb_pipe_rx_deframer;

  localparam int BL_TB    = 1024;
  localparam int DEPTH_TB = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pipe_we = 1'b0;
  logic [15:0] pipe_din = 16'h0000;
  logic        out_ready = 1'b0;
  logic        wr_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        block_done;
  logic        overflow;
  logic [11:0] level;

  logic        s_we = 1'b0;
  logic [15:0] s_din = 16'h0000;
  logic        s_ready = 1'b0;
  logic        s_wr_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_block_done;
  logic        s_overflow;
  logic [2:0]  s_level;

  int total = 0;
  int bad = 0;
  int bd_count = 0;

  logic [15:0] m_mem[$];
  logic        m_full = 1'b0;
  logic [15:0] m_word = 16'h0000;
  logic        m_ovf = 1'b0;
  int          m_bcnt = 0;
  logic        m_bd = 1'b0;
  logic        m_wrr = 1'b0;

  pipe_rx_deframer #(.BLOCK_LEN(BL_TB), .DEPTH(DEPTH_TB), .AW(11)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_we(pipe_we), .pipe_din(pipe_din),
    .wr_ready(wr_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .block_done(block_done), .overflow(overflow), .level(level)
  );

  pipe_rx_deframer #(.BLOCK_LEN(1), .DEPTH(4), .AW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .pipe_we(s_we), .pipe_din(s_din),
    .wr_ready(s_wr_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_ready), .block_done(s_block_done), .overflow(s_overflow), .level(s_level)
  );

  always #5 clk = ~clk;

  // One clock of traffic on the large DUT, with the model advanced by the same rules
  task automatic cycle(input logic we, input logic [15:0] din, input logic rdy);
    int   sz;
    logic pop;
    logic load;
    logic nwrr;
    pipe_we   = we;
    pipe_din  = din;
    out_ready = rdy;
    @(posedge clk);
    sz   = m_mem.size();
    pop  = m_full && rdy;
    load = (sz > 0) && (!m_full || pop);
    nwrr = (m_bcnt == 0) && !we && ((DEPTH_TB - sz) >= BL_TB);
    if (load) begin
      m_word = m_mem.pop_front();
      m_full = 1'b1;
    end else if (pop) begin
      m_full = 1'b0;
    end
    if (we) begin
      if (sz < DEPTH_TB) m_mem.push_back(din);
      else m_ovf = 1'b1;
      m_bcnt++;
      if (m_bcnt == BL_TB) begin
        m_bd   = 1'b1;
        m_bcnt = 0;
      end else begin
        m_bd = 1'b0;
      end
    end else begin
      m_bd = 1'b0;
    end
    m_wrr = nwrr;
    #1;
    if (block_done === 1'b1) bd_count++;
    total++;
    if (out_valid !== m_full) begin
      bad++; $display("FAIL out_valid at %0t: got %b expected %b", $time, out_valid, m_full);
    end
    if (m_full) begin
      total++;
      if (out_data !== m_word) begin
        bad++; $display("FAIL out_data at %0t: got %h expected %h", $time, out_data, m_word);
      end
    end
    total++;
    if (level !== 12'(m_mem.size())) begin
      bad++; $display("FAIL level at %0t: got %0d expected %0d", $time, level, m_mem.size());
    end
    total++;
    if (overflow !== m_ovf) begin
      bad++; $display("FAIL overflow at %0t: got %b expected %b", $time, overflow, m_ovf);
    end
    total++;
    if (block_done !== m_bd) begin
      bad++; $display("FAIL block_done at %0t: got %b expected %b", $time, block_done, m_bd);
    end
    total++;
    if (wr_ready !== m_wrr) begin
      bad++; $display("FAIL wr_ready at %0t: got %b expected %b", $time, wr_ready, m_wrr);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_we = 1'b0; out_ready = 1'b0; s_we = 1'b0; s_ready = 1'b0;
    #1;
    total++;
    if ({wr_ready, out_valid, out_data, block_done, overflow, level} !== 32'h0) begin
      bad++;
      $display("FAIL reset_values: got wr_ready=%b out_valid=%b out_data=%h block_done=%b overflow=%b level=%0d expected all zero",
               wr_ready, out_valid, out_data, block_done, overflow, level);
    end
    total++;
    if ({s_wr_ready, s_out_valid, s_block_done, s_overflow, s_level} !== 7'h0) begin
      bad++; $display("FAIL small_reset_values: got level=%0d overflow=%b expected zero", s_level, s_overflow);
    end
    m_mem.delete(); m_full = 1'b0; m_word = 16'h0000; m_ovf = 1'b0;
    m_bcnt = 0; m_bd = 1'b0; m_wrr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8000; i++) begin
      if (!m_full && m_mem.size() == 0) break;
      cycle(1'b0, 16'h0000, 1'($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 16'h0000, 1'b1);
    total++;
    if (out_valid !== 1'b0 || level !== 12'd0) begin
      bad++; $display("FAIL drain_empty: got out_valid=%b level=%0d expected 0 and 0", out_valid, level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    total++;
    if (wr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_wr_ready: got %b expected 1", wr_ready);
    end
  endtask

  task automatic test_one_block();
    bd_count = 0;
    for (int i = 0; i < BL_TB; i++) cycle(1'b1, 16'(i), 1'b1);
    repeat (4) cycle(1'b0, 16'h0000, 1'b1);
    total++;
    if (bd_count != 1) begin
      bad++; $display("FAIL one_block_done_count: got %0d expected 1", bd_count);
    end
    total++;
    if (level !== 12'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL one_block_empty: got level=%0d out_valid=%b expected 0", level, out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2 * BL_TB; i++) cycle(1'b1, 16'($urandom), 1'b0);
    total++;
    if (level !== 12'd2047 || out_valid !== 1'b1 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL two_blocks_fill: got level=%0d out_valid=%b wr_ready=%b expected 2047 1 0",
                      level, out_valid, wr_ready);
    end
    for (int i = 0; i < 100; i++) cycle(1'b1, 16'($urandom), 1'b0);
    repeat (50) cycle(1'b0, 16'h0000, 1'($urandom_range(0, 1)));
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
    drain();
  endtask

  task automatic test_simul();
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2 * BL_TB; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1);
    total++;
    if (level !== 12'd2047 || overflow !== 1'b0) begin
      bad++; $display("FAIL simul_write_pop: got level=%0d overflow=%b expected 2047 0", level, overflow);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3000; i++) cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    drain();
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    for (int i = 0; i < 2 * BL_TB; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1);
      if (i >= 1 && out_valid !== 1'b1) gaps++;
    end
    total++;
    if (gaps != 0) begin
      bad++; $display("FAIL back_to_back_bubbles: got %0d expected 0", gaps);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
    do_reset();
    cycle(1'b0, 16'h0000, 1'b1);
    bd_count = 0;
    for (int i = 0; i < BL_TB; i++) cycle(1'b1, 16'($urandom), 1'b1);
    repeat (3) cycle(1'b0, 16'h0000, 1'b1);
    total++;
    if (bd_count != 1) begin
      bad++; $display("FAIL reset_mid_done_count: got %0d expected 1", bd_count);
    end
  endtask

  task automatic test_single_word_blocks();
    do_reset();
    @(posedge clk); #1;
    s_ready = 1'b0;
    // Memory holds 4 and the output register 1, so the sixth word is the first dropped
    for (int k = 1; k <= 6; k++) begin
      s_we = 1'b1; s_din = 16'(k);
      @(posedge clk); #1;
      total++;
      if (s_block_done !== 1'b1) begin
        bad++; $display("FAIL small_block_done word %0d: got %b expected 1", k, s_block_done);
      end
      total++;
      if (s_overflow !== (k == 6)) begin
        bad++; $display("FAIL small_overflow word %0d: got %b expected %b", k, s_overflow, (k == 6));
      end
    end
    s_we = 1'b0;
    @(posedge clk); #1;
    total++;
    if (s_block_done !== 1'b0 || s_level !== 3'd4 || s_out_valid !== 1'b1) begin
      bad++; $display("FAIL small_full: got done=%b level=%0d valid=%b expected 0 4 1",
                      s_block_done, s_level, s_out_valid);
    end
    s_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (s_out_valid !== 1'b1 || s_out_data !== 16'(k)) begin
        bad++; $display("FAIL small_order: got valid=%b data=%h expected 1 %h", s_out_valid, s_out_data, 16'(k));
      end
      @(posedge clk); #1;
    end
    total++;
    if (s_out_valid !== 1'b0 || s_overflow !== 1'b1) begin
      bad++; $display("FAIL small_drained: got valid=%b overflow=%b expected 0 1", s_out_valid, s_overflow);
    end
    s_ready = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_one_block();
    test_overflow();
    test_simul();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_single_word_blocks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete within the time budget");
    $fatal(1, "timeout");
  end

endmodule
